// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, register-file read, immediate
// generation, load-use hazard detection and the ID/EX pipeline register.
module id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifid_valid,
  input  logic [31:0]     ifid_instr,
  input  logic [XLEN-1:0] ifid_pc,
  input  logic            ex_hold,
  input  logic            flush,
  output logic [4:0]      rf_read1,
  output logic [4:0]      rf_read2,
  input  logic [XLEN-1:0] rf_out1,
  input  logic [XLEN-1:0] rf_out2,
  output logic            id_stall,
  output logic            idex_valid,
  output logic [XLEN-1:0] idex_pc,
  output logic [XLEN-1:0] idex_rs1_val,
  output logic [XLEN-1:0] idex_rs2_val,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic [2:0]      idex_funct3,
  output logic            idex_funct7b5,
  output logic [3:0]      idex_opclass,
  output logic            idex_reg_we,
  output logic            idex_mem_re,
  output logic            idex_mem_we,
  output logic            idex_alu_imm,
  output logic            idex_illegal
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef enum logic [3:0] {
    C_ILLEGAL = 4'd0,
    C_LUI     = 4'd1,
    C_AUIPC   = 4'd2,
    C_JAL     = 4'd3,
    C_JALR    = 4'd4,
    C_BRANCH  = 4'd5,
    C_LOAD    = 4'd6,
    C_STORE   = 4'd7,
    C_OPIMM   = 4'd8,
    C_OP      = 4'd9,
    C_SYSTEM  = 4'd10
  } opclass_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7b5;
    opclass_e        opclass;
    logic            reg_we;
    logic            mem_re;
    logic            mem_we;
    logic            alu_imm;
    logic            illegal;
  } idex_t;

  idex_t dec, q;

  logic [31:0]     ins;
  logic [4:0]      rs1, rs2, rd;
  logic            uses_rs1, uses_rs2, writes_rd, hazard;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign ins = ifid_instr;
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  assign rf_read1 = rs1;
  assign rf_read2 = rs2;

  assign imm_i = {{(XLEN-12){ins[31]}}, ins[31:20]};
  assign imm_s = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){ins[31]}}, ins[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Full 7-bit opcode match, so any encoding with ins[1:0] != 2'b11 falls to illegal.
  always_comb begin
    dec       = '0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    dec.valid = 1'b1;
    dec.pc    = ifid_pc;
    unique case (ins[6:0])
      OP_LUI: begin
        dec.opclass = C_LUI;   writes_rd = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_u;
      end
      OP_AUIPC: begin
        dec.opclass = C_AUIPC; writes_rd = 1'b1; dec.alu_imm = 1'b1; dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.opclass = C_JAL;   writes_rd = 1'b1; dec.imm = imm_j;
      end
      OP_JALR: begin
        dec.opclass = C_JALR;  writes_rd = 1'b1; uses_rs1 = 1'b1;
        dec.alu_imm = 1'b1;    dec.imm = imm_i;  dec.funct3 = ins[14:12];
      end
      OP_BRANCH: begin
        dec.opclass = C_BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm = imm_b;        dec.funct3 = ins[14:12];
      end
      OP_LOAD: begin
        dec.opclass = C_LOAD;  writes_rd = 1'b1; uses_rs1 = 1'b1; dec.mem_re = 1'b1;
        dec.alu_imm = 1'b1;    dec.imm = imm_i;  dec.funct3 = ins[14:12];
      end
      OP_STORE: begin
        dec.opclass = C_STORE; uses_rs1 = 1'b1; uses_rs2 = 1'b1; dec.mem_we = 1'b1;
        dec.alu_imm = 1'b1;    dec.imm = imm_s; dec.funct3 = ins[14:12];
      end
      OP_IMM: begin
        dec.opclass = C_OPIMM; writes_rd = 1'b1; uses_rs1 = 1'b1;
        dec.alu_imm = 1'b1;    dec.imm = imm_i;  dec.funct3 = ins[14:12];
        // Only shifts carry a meaningful instr[30] (SRLI vs SRAI).
        dec.funct7b5 = (ins[13:12] == 2'b01) ? ins[30] : 1'b0;
      end
      OP_REG: begin
        dec.opclass  = C_OP;   writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.funct3   = ins[14:12];
        dec.funct7b5 = ins[30];
      end
      OP_SYSTEM, OP_FENCE: begin
        dec.opclass = C_SYSTEM; dec.funct3 = ins[14:12];
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.rs1     = uses_rs1 ? rs1 : 5'd0;
    dec.rs2     = uses_rs2 ? rs2 : 5'd0;
    dec.reg_we  = writes_rd && (rd != 5'd0);
    dec.rd      = dec.reg_we ? rd : 5'd0;
    dec.rs1_val = uses_rs1 ? rf_out1 : '0;
    dec.rs2_val = uses_rs2 ? rf_out2 : '0;
  end

  // A load in EX whose destination is read here cannot be forwarded in time.
  assign hazard = q.valid && q.mem_re && (q.rd != 5'd0) && ifid_valid &&
                  ((uses_rs1 && (rs1 == q.rd)) || (uses_rs2 && (rs2 == q.rd)));

  assign id_stall = rst_n && !flush && (ex_hold || hazard);

  always_ff @(posedge clk) begin
    if (!rst_n)          q <= '0;
    else if (flush)      q <= '0;
    else if (ex_hold)    q <= q;
    else if (hazard)     q <= '0;
    else if (ifid_valid) q <= dec;
    else                 q <= '0;
  end

  assign idex_valid    = q.valid;
  assign idex_pc       = q.pc;
  assign idex_rs1_val  = q.rs1_val;
  assign idex_rs2_val  = q.rs2_val;
  assign idex_imm      = q.imm;
  assign idex_rs1      = q.rs1;
  assign idex_rs2      = q.rs2;
  assign idex_rd       = q.rd;
  assign idex_funct3   = q.funct3;
  assign idex_funct7b5 = q.funct7b5;
  assign idex_opclass  = q.opclass;
  assign idex_reg_we   = q.reg_we;
  assign idex_mem_re   = q.mem_re;
  assign idex_mem_we   = q.mem_we;
  assign idex_alu_imm  = q.alu_imm;
  assign idex_illegal  = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, immediates, load-use stall, hold,
// flush priority, reset and illegal encodings.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, ifid_valid, ex_hold, flush;
  logic [31:0] ifid_instr, ifid_pc;
  logic [4:0]  rf_read1, rf_read2;
  logic [31:0] rf_out1, rf_out2;
  logic        id_stall, idex_valid;
  logic [31:0] idex_pc, idex_rs1_val, idex_rs2_val, idex_imm;
  logic [4:0]  idex_rs1, idex_rs2, idex_rd;
  logic [2:0]  idex_funct3;
  logic        idex_funct7b5;
  logic [3:0]  idex_opclass;
  logic        idex_reg_we, idex_mem_re, idex_mem_we, idex_alu_imm, idex_illegal;

  logic [31:0] regs [32];
  int n_chk = 0;
  int n_fail = 0;

  localparam logic [31:0] I_ADDI = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_LW   = 32'h00012183; // lw   x3,0(x2)
  localparam logic [31:0] I_ADD  = 32'h00118233; // add  x4,x3,x1
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_JAL  = 32'h0010006F; // jal  x0,+2048

  always #5 clk = ~clk;

  assign rf_out1 = (rf_read1 == 5'd0) ? 32'd0 : regs[rf_read1];
  assign rf_out2 = (rf_read2 == 5'd0) ? 32'd0 : regs[rf_read2];

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc(ifid_pc), .ex_hold(ex_hold), .flush(flush),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_out1(rf_out1), .rf_out2(rf_out2),
    .id_stall(id_stall), .idex_valid(idex_valid), .idex_pc(idex_pc),
    .idex_rs1_val(idex_rs1_val), .idex_rs2_val(idex_rs2_val), .idex_imm(idex_imm),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
    .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
    .idex_opclass(idex_opclass), .idex_reg_we(idex_reg_we),
    .idex_mem_re(idex_mem_re), .idex_mem_we(idex_mem_we),
    .idex_alu_imm(idex_alu_imm), .idex_illegal(idex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    ifid_valid = v;
    ifid_instr = ins;
    ifid_pc    = pc;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = i * 10;
    rst_n = 1'b0; ex_hold = 1'b1; flush = 1'b0;
    drive(1'b1, I_ADDI, 32'h100);

    // Reset: register cleared, no stall even with hold raised
    tick();
    chk("rst_valid", {31'd0, idex_valid}, 32'd0);
    chk("rst_opclass", {28'd0, idex_opclass}, 32'd0);
    chk("rst_imm", idex_imm, 32'd0);
    chk("rst_pc", idex_pc, 32'd0);
    chk("rst_stall", {31'd0, id_stall}, 32'd0);

    // ADDI decode
    rst_n = 1'b1; ex_hold = 1'b0;
    drive(1'b1, I_ADDI, 32'h100);
    chk("addi_rdaddr1", {27'd0, rf_read1}, 32'd1);
    chk("addi_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, idex_valid}, 32'd1);
    chk("addi_opclass", {28'd0, idex_opclass}, 32'd8);
    chk("addi_rd", {27'd0, idex_rd}, 32'd5);
    chk("addi_rs1val", idex_rs1_val, 32'd10);
    chk("addi_imm", idex_imm, 32'hFFFFFFFD);
    chk("addi_regwe", {31'd0, idex_reg_we}, 32'd1);
    chk("addi_aluimm", {31'd0, idex_alu_imm}, 32'd1);
    chk("addi_pc", idex_pc, 32'h100);
    chk("addi_rs2", {27'd0, idex_rs2}, 32'd0);

    // Load-use: one bubble, then the add is captured
    drive(1'b1, I_LW, 32'h104);
    tick();
    chk("lw_memre", {31'd0, idex_mem_re}, 32'd1);
    chk("lw_rd", {27'd0, idex_rd}, 32'd3);
    drive(1'b1, I_ADD, 32'h108);
    chk("lu_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, idex_valid}, 32'd0);
    chk("lu_bubble_memre", {31'd0, idex_mem_re}, 32'd0);
    chk("lu_stall_clear", {31'd0, id_stall}, 32'd0);
    tick();
    chk("add_valid", {31'd0, idex_valid}, 32'd1);
    chk("add_opclass", {28'd0, idex_opclass}, 32'd9);
    chk("add_rd", {27'd0, idex_rd}, 32'd4);
    chk("add_rs1val", idex_rs1_val, 32'd30);
    chk("add_rs2val", idex_rs2_val, 32'd10);
    chk("add_aluimm", {31'd0, idex_alu_imm}, 32'd0);

    // Branch immediate
    drive(1'b1, I_BEQ, 32'h10C);
    tick();
    chk("beq_opclass", {28'd0, idex_opclass}, 32'd5);
    chk("beq_imm", idex_imm, 32'hFFFFFFF8);
    chk("beq_rs2", {27'd0, idex_rs2}, 32'd2);
    chk("beq_rs2val", idex_rs2_val, 32'd20);
    chk("beq_regwe", {31'd0, idex_reg_we}, 32'd0);
    chk("beq_rd", {27'd0, idex_rd}, 32'd0);

    // JAL to x0
    drive(1'b1, I_JAL, 32'h110);
    tick();
    chk("jal_opclass", {28'd0, idex_opclass}, 32'd3);
    chk("jal_rd", {27'd0, idex_rd}, 32'd0);
    chk("jal_regwe", {31'd0, idex_reg_we}, 32'd0);
    chk("jal_imm", idex_imm, 32'h00000800);

    // Hold for 3 cycles with changing IF/ID contents
    ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0) ? I_ADDI : (i == 1) ? I_ADD : I_BEQ, 32'h200 + i * 4);
      chk("hold_stall", {31'd0, id_stall}, 32'd1);
      tick();
      chk("hold_imm", idex_imm, 32'h00000800);
      chk("hold_pc", idex_pc, 32'h110);
    end
    ex_hold = 1'b0;
    drive(1'b1, I_ADDI, 32'h300);
    tick();
    chk("release_opclass", {28'd0, idex_opclass}, 32'd8);
    chk("release_pc", idex_pc, 32'h300);

    // Hazard together with hold: hold wins
    drive(1'b1, I_LW, 32'h304);
    tick();
    ex_hold = 1'b1;
    drive(1'b1, I_ADD, 32'h308);
    chk("hazhold_stall", {31'd0, id_stall}, 32'd1);
    tick();
    chk("hazhold_memre", {31'd0, idex_mem_re}, 32'd1);
    chk("hazhold_pc", idex_pc, 32'h304);

    // Flush beats hold and hazard
    flush = 1'b1;
    #1;
    chk("flush_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("flush_valid", {31'd0, idex_valid}, 32'd0);
    chk("flush_pc", idex_pc, 32'd0);
    flush = 1'b0; ex_hold = 1'b0;

    // Reset mid-stream, with hold raised
    drive(1'b1, I_ADDI, 32'h400);
    tick();
    chk("pre_rst_valid", {31'd0, idex_valid}, 32'd1);
    rst_n = 1'b0; ex_hold = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, id_stall}, 32'd0);
    tick();
    chk("rst_mid_valid", {31'd0, idex_valid}, 32'd0);
    chk("rst_mid_rd", {27'd0, idex_rd}, 32'd0);
    chk("rst_mid_imm", idex_imm, 32'd0);
    chk("rst_mid_regwe", {31'd0, idex_reg_we}, 32'd0);
    chk("rst_mid_rs1val", idex_rs1_val, 32'd0);
    rst_n = 1'b1; ex_hold = 1'b0;

    // Illegal all-zero word
    drive(1'b1, 32'h00000000, 32'h500);
    tick();
    chk("ill_flag", {31'd0, idex_illegal}, 32'd1);
    chk("ill_opclass", {28'd0, idex_opclass}, 32'd0);
    chk("ill_ctl", {29'd0, idex_reg_we, idex_mem_re, idex_mem_we}, 32'd0);
    chk("ill_valid", {31'd0, idex_valid}, 32'd1);

    // Invalid IF/ID slot captures an empty entry
    drive(1'b0, I_ADDI, 32'h600);
    tick();
    chk("inv_valid", {31'd0, idex_valid}, 32'd0);
    chk("inv_imm", idex_imm, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
